dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder that serves load/store requests from the pipelined CPU's MEM stage. It answers through a req/ready/ack handshake with a programmable number of wait states. It backs a word-organised storage array. It replaces the zero-latency data memory so the CPU's stall logic can be exercised against realistic memory latency.

## Interface
Parameters:
- DEPTH_WORDS, 128: number of 32-bit words; power of two, 4..4096.
- WAIT_CYCLES, 2: wait states inserted between accept and response; 0..15.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset. One clock, synchronous active-high reset (decided).
- req_i  in  1  request valid; requester holds it, together with its payload, until accepted.
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data.
- ready_o  out  1  responder can accept; a request is accepted on an edge where req_i && ready_o.
- ack_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  load data; valid while ack_o = 1, held until the next ack.
- busy_o  out  1  transaction in flight (WAIT or RESP).
- err_o  out  1  misaligned-access flag, qualified by ack_o (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ready_o = 1.
  - On accept, latch we_i, addr_i and wdata_i into internal registers.
  - Go to WAIT with cnt = WAIT_CYCLES-1, or go directly to RESP if WAIT_CYCLES = 0.
- WAIT:
  - ready_o = 0.
  - cnt decrements each cycle; at cnt = 0, go to RESP.
- RESP:
  - ack_o = 1.
  - A load drives rdata_o = mem[idx].
  - A store writes mem[idx] = latched wdata; rdata_o holds its previous value.
  - Unconditionally returns to IDLE.
- Word index idx = latched addr[2+log2(DEPTH_WORDS)-1 : 2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4 bytes.
- During WAIT/RESP, req_i and the payload inputs are ignored. Deasserting req_i mid-transaction does not cancel it.
- Memory contents are not cleared by reset; the simulation initial value is 0.

## Timing
- Request accepted at the edge ending cycle T:
  - WAIT occupies cycles T+1..T+WAIT_CYCLES.
  - ack_o is high in cycle T+WAIT_CYCLES+1.
  - ready_o returns high in cycle T+WAIT_CYCLES+2.
- Throughput is one transaction per WAIT_CYCLES+2 cycles.
- A store commits at the edge ending its RESP cycle. A load accepted afterwards returns the new data.
- Reset values: ready_o 0 while rst_i is high, then 1 from the first cycle after release; ack_o 0, rdata_o 0, err_o 0, busy_o 0; FSM IDLE, cnt 0.
- Reset mid-transaction: the transaction is abandoned with no ack.
  - If rst_i is high in the RESP cycle, the store is suppressed, because reset takes priority over the write.
- busy_o = (state != IDLE).

## Configuration
- Macro DMEM_MISALIGN_ERR_EN.
- Defined:
  - A request with latched addr[1:0] != 0 completes with normal timing.
  - In RESP: err_o = 1 alongside ack_o, a store is suppressed, and load rdata_o = 0.
  - err_o is 0 whenever ack_o is 0.
- Undefined:
  - addr[1:0] is ignored and the access proceeds to the word index.
  - err_o is tied to 0.

## Test plan
- WAIT_CYCLES=2: store addr 0x10, data 0xDEADBEEF accepted at T -> ack_o in T+3 only. Then load 0x10 -> rdata_o = 0xDEADBEEF during its ack cycle.
- WAIT_CYCLES=0, req_i held high for 6 cycles with loads to 0x0, 0x4, 0x8 -> exactly three accepts, ack_o every second cycle, ready_o alternating 1/0.
- DEPTH_WORDS=128: store 0x55 to 0x200 (wraps to idx 0) -> load from 0x0 returns 0x55.
- Macro defined: store 0xFFFFFFFF to 0x12 -> ack_o and err_o both 1, err_o low in all other cycles, and a subsequent load of 0x10 returns its prior value. Macro undefined, same stimulus -> err_o = 0 and the load of 0x10 returns 0xFFFFFFFF.
- WAIT_CYCLES=3: store 0x1234 to 0x20, assert rst_i for one cycle during WAIT -> no ack_o, busy_o 0 and ready_o 1 after release, and a load of 0x20 returns the old contents.
- req_i dropped one cycle after accept, WAIT_CYCLES=2 -> ack_o still pulses at T+3, and no second transaction starts.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word-organised data memory behind a
// req/ready/ack handshake, with WAIT_CYCLES wait states per transaction.
// Optional feature macro: DMEM_MISALIGN_ERR_EN. When it is defined, an access
// with addr[1:0] != 0 completes with err_o = 1, suppresses its store, and
// returns 0 for a load. When it is undefined, addr[1:0] is ignored and
// err_o is tied to 0.

module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               accept;

    // Latched request payload
    logic               we_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  wdata_q;

    // Request currently heading for RESP: live inputs in IDLE, latched copy after
    logic               we_sel;
    logic [IDX_W-1:0]   idx_sel;
    logic               mis_sel;

    logic [DATA_W-1:0]  mem [DEPTH_WORDS];

    // Address bits outside the word index never influence the access
    logic               unused_addr;

`ifdef DMEM_MISALIGN_ERR_EN
    logic               mis_q;

    assign unused_addr = ^addr_i[31:IDX_W+2];

    // Misalignment of the request being served
    assign mis_sel = (state_q == IDLE) ? (addr_i[1:0] != 2'b00) : mis_q;

    // Latch the misalignment flag alongside the rest of the payload
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mis_q <= (addr_i[1:0] != 2'b00);
        end
    end
`else
    assign unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};
    assign mis_sel     = 1'b0;
`endif

    assign we_sel  = (state_q == IDLE) ? we_i : we_q;
    assign idx_sel = (state_q == IDLE) ? addr_i[IDX_W+1:2] : idx_q;

    // Acceptance is only possible in IDLE and is masked while reset is held
    assign ready_o = (state_q == IDLE) && !rst_i;

    // Next-state and wait-counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i && !rst_i) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers; reset abandons any transaction in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request payload on accept
    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q    <= we_i;
            idx_q   <= addr_i[IDX_W+1:2];
            wdata_q <= wdata_i;
        end
    end

    // Registered handshake outputs, set up on the edge that enters RESP
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_o   <= 1'b0;
            busy_o  <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            ack_o  <= (state_d == RESP);
            busy_o <= (state_d != IDLE);
            err_o  <= (state_d == RESP) && mis_sel;
            if ((state_d == RESP) && !we_sel) begin
                rdata_o <= mis_sel ? '0 : mem[idx_sel];
            end
        end
    end

    // Store commits at the end of RESP; reset and misalignment both veto it
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_q == RESP) && we_q && !mis_sel) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// load/store traffic checked against a word-array reference model.

module tb_dmem_responder;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned WAITC = 2;
    localparam int unsigned PER   = WAITC + 2;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        ack;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    int          checks = 0;
    int          errors = 0;

    // Reference model: plain word array plus the last value seen on rdata
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rd;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .ready_o (ready),
        .ack_o   (ack),
        .rdata_o (rdata),
        .busy_o  (busy),
        .err_o   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic bit misaligned(input logic [31:0] a);
        return MIS_EN && ((a % 4) != 0);
    endfunction

    // One full transaction starting at a negedge with the responder idle;
    // req is dropped right after accept and the payload scrambled.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d);
        int          waitc;
        bit          mis;
        int          i;
        logic [31:0] exp_rd;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        waitc = 0;
        while (ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("accept_wait", 32'(waitc < 20), 32'd1);
        @(posedge clk);
        #1;
        req   = 1'b0;
        we    = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        mis   = misaligned(a);
        i     = widx(a);
        for (int k = 1; k <= int'(WAITC) + 1; k++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'd1);
            chk("ready_in_flight", 32'(ready), 32'd0);
            chk("ack", 32'(ack), 32'(k == int'(WAITC) + 1));
            chk("err", 32'(err), 32'((k == int'(WAITC) + 1) && mis));
        end
        if (w) exp_rd = last_rd;
        else   exp_rd = mis ? 32'd0 : model_mem[i];
        chk("rdata", rdata, exp_rd);
        last_rd = exp_rd;
        if (w && !mis) model_mem[i] = d;
        @(negedge clk);
        chk("ready_after", 32'(ready), 32'd1);
        chk("ack_after", 32'(ack), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("err_after", 32'(err), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] a;
        for (int k = 0; k < int'(DEPTH); k++) model_mem[k] = 32'd0;
        last_rd = 32'd0;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_post_rst", 32'(ready), 32'd1);

        // Fill every word with known data
        for (int k = 0; k < int'(DEPTH); k++) do_txn(1'b1, 32'(k * 4), $urandom);

        // Store then load back
        do_txn(1'b1, 32'h10, 32'hDEADBEEF);
        do_txn(1'b0, 32'h10, 32'd0);
        chk("load_deadbeef", last_rd, 32'hDEADBEEF);

        // Address wrap: 0x200 aliases word 0
        do_txn(1'b1, 32'h200, 32'h55);
        do_txn(1'b0, 32'h0, 32'd0);
        chk("wrap_load", last_rd, 32'h55);

        // Misaligned store, then aligned load of the same word
        do_txn(1'b1, 32'h12, 32'hFFFFFFFF);
        do_txn(1'b0, 32'h10, 32'd0);
        chk("misalign_load", last_rd, MIS_EN ? 32'hDEADBEEF : 32'hFFFFFFFF);

        // req held high: back-to-back loads of 0x0, 0x4, 0x8
        req = 1'b1; we = 1'b0; addr = 32'h0; n = 0;
        for (int c = 0; c < 3 * int'(PER); c++) begin
            chk("tp_ready", 32'(ready), 32'((c % int'(PER)) == 0));
            chk("tp_ack", 32'(ack), 32'((c % int'(PER)) == int'(PER) - 1));
            if ((c % int'(PER)) == int'(PER) - 1) begin
                chk("tp_rdata", rdata, model_mem[c / int'(PER)]);
                last_rd = model_mem[c / int'(PER)];
            end
            @(posedge clk);
            #1;
            if ((c % int'(PER)) == 0) begin
                n++;
                if (n == 3) req = 1'b0;
                else addr = 32'(4 * n);
            end
            @(negedge clk);
        end
        for (int c = 0; c < 3; c++) begin
            chk("tp_idle_ack", 32'(ack), 32'd0);
            chk("tp_idle_ready", 32'(ready), 32'd1);
            @(negedge clk);
        end

        // Reset during WAIT abandons the store
        do_txn(1'b1, 32'h20, 32'hCAFE0001);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_rd = 32'd0;
        for (int c = 0; c < int'(PER); c++) begin
            @(negedge clk);
            chk("rstw_ack", 32'(ack), 32'd0);
            chk("rstw_busy", 32'(busy), 32'd0);
            chk("rstw_ready", 32'(ready), 32'd1);
        end
        do_txn(1'b0, 32'h20, 32'd0);
        chk("rstw_load", last_rd, 32'hCAFE0001);

        // Reset during RESP suppresses the store
        req = 1'b1; we = 1'b1; addr = 32'h24; wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int c = 0; c < int'(WAITC); c++) @(negedge clk);
        @(negedge clk);
        chk("rstr_ack", 32'(ack), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_rd = 32'd0;
        @(negedge clk);
        chk("rstr_ack_gone", 32'(ack), 32'd0);
        chk("rstr_ready", 32'(ready), 32'd1);
        do_txn(1'b0, 32'h24, 32'd0);
        chk("rstr_load", last_rd, model_mem[9]);

        // Random traffic, including misaligned and high address bits
        for (int k = 0; k < 150; k++) begin
            a = $urandom;
            do_txn(1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
